// File: rtl/repetition_pkg.sv
// Shared definitions for the repetition-coded link (transmitter and majority-voter receiver).
package repetition_pkg;
   typedef enum logic {IDLE, SEND} state_t;

   localparam int DEF_DATA_W = 8;
   localparam int DEF_REP    = 3;

   // Counter width for a count range of n values, never narrower than one bit
   function automatic int cnt_w(input int n);
      return (n <= 2) ? 1 : $clog2(n);
   endfunction

   localparam int DEF_REP_CW = cnt_w(DEF_REP);
   localparam int DEF_BIT_CW = cnt_w(DEF_DATA_W);
endpackage

// File: rtl/rep_slot_counter.sv
// Nested repetition/bit slot counter: rep_cnt runs inside bit_cnt, both return to zero at frame end.
module rep_slot_counter
   import repetition_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REP    = DEF_REP,
   parameter int RW     = cnt_w(REP),
   parameter int BW     = cnt_w(DATA_W)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          clr,
   input  logic          adv,
   output logic [RW-1:0] rep_cnt,
   output logic [BW-1:0] bit_cnt,
   output logic          last_rep,
   output logic          last_bit
);
   localparam logic [RW-1:0] REP_LAST = RW'(REP - 1);
   localparam logic [BW-1:0] BIT_LAST = BW'(DATA_W - 1);

   assign last_rep = (rep_cnt == REP_LAST);
   assign last_bit = (bit_cnt == BIT_LAST);

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rep_cnt <= '0;
         bit_cnt <= '0;
      end else if (clr) begin
         rep_cnt <= '0;
         bit_cnt <= '0;
      end else if (adv) begin
         rep_cnt <= last_rep ? '0 : rep_cnt + 1'b1;
         if (last_rep)
            bit_cnt <= last_bit ? '0 : bit_cnt + 1'b1;
      end
   end
endmodule

// File: rtl/repetition_encoder_tx.sv
// Serial repetition-code transmitter: LSB-first, each bit presented on REP consecutive line slots.
module repetition_encoder_tx
   import repetition_pkg::*;
#(
   parameter int DATA_W = DEF_DATA_W,
   parameter int REP    = DEF_REP
) (
   input  logic              CLK,
   input  logic              RST,
   input  logic [DATA_W-1:0] DIN,
   input  logic              DIN_VALID,
   output logic              DIN_READY,
   output logic              TX_OUT,
   output logic              TX_VALID,
   input  logic              TX_READY,
   output logic              TX_SOF,
   output logic              DONE
);
   localparam int RW = cnt_w(REP);
   localparam int BW = cnt_w(DATA_W);

   state_t            state;
   logic [DATA_W-1:0] shreg, shreg_nx;
   logic [RW-1:0]     rep_cnt;
   logic [BW-1:0]     bit_cnt;
   logic              last_rep, last_bit;
   logic              accept, consume;

   assign accept   = (state == IDLE) && DIN_VALID && DIN_READY;
   assign consume  = (state == SEND) && TX_VALID && TX_READY;
   assign shreg_nx = shreg >> 1;

   rep_slot_counter #(.DATA_W(DATA_W), .REP(REP), .RW(RW), .BW(BW)) u_cnt (
      .clk      (CLK),
      .rst      (RST),
      .clr      (accept),
      .adv      (consume),
      .rep_cnt  (rep_cnt),
      .bit_cnt  (bit_cnt),
      .last_rep (last_rep),
      .last_bit (last_bit)
   );

   // Outputs are computed one edge ahead so every port comes straight from a flop
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         shreg     <= '0;
         TX_OUT    <= 1'b0;
         TX_VALID  <= 1'b0;
         TX_SOF    <= 1'b0;
         DONE      <= 1'b0;
         DIN_READY <= 1'b0;
      end else begin
         DONE <= 1'b0;
         case (state)
            IDLE: begin
               DIN_READY <= 1'b1;
               if (accept) begin
                  shreg     <= DIN;
                  TX_OUT    <= DIN[0];
                  TX_VALID  <= 1'b1;
                  TX_SOF    <= 1'b1;
                  DIN_READY <= 1'b0;
                  state     <= SEND;
               end
            end
            SEND: begin
               if (consume) begin
                  TX_SOF <= 1'b0;
                  if (last_rep) begin
                     shreg  <= shreg_nx;
                     TX_OUT <= shreg_nx[0];
                     if (last_bit) begin
                        TX_VALID  <= 1'b0;
                        TX_OUT    <= 1'b0;
                        DONE      <= 1'b1;
                        DIN_READY <= 1'b1;
                        state     <= IDLE;
                     end
                  end
               end
            end
         endcase
      end
   end

   logic unused;
   assign unused = ^{rep_cnt, bit_cnt};
endmodule

// File: tb/tb_repetition_encoder_tx.sv
// Scoreboard bench for repetition_encoder_tx with a loopback majority-vote receiver.
module tb_repetition_encoder_tx;
   localparam int DATA_W = 8;
   localparam int REP    = 3;
   localparam int NSLOT  = DATA_W * REP;

   logic              CLK = 0;
   logic              RST = 1;
   logic [DATA_W-1:0] DIN = '0;
   logic              DIN_VALID = 0;
   logic              DIN_READY;
   logic              TX_OUT, TX_VALID, TX_SOF, DONE;
   logic              TX_READY = 1;

   int checks = 0;
   int errors = 0;

   repetition_encoder_tx #(.DATA_W(DATA_W), .REP(REP)) dut (
      .CLK(CLK), .RST(RST), .DIN(DIN), .DIN_VALID(DIN_VALID), .DIN_READY(DIN_READY),
      .TX_OUT(TX_OUT), .TX_VALID(TX_VALID), .TX_READY(TX_READY), .TX_SOF(TX_SOF), .DONE(DONE)
   );

   always #5 CLK = ~CLK;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   // Scoreboard: expected slots {bit, sof} and expected recovered words
   logic [1:0]        slot_q[$];
   logic [DATA_W-1:0] word_q[$];
   int                rdy_mode = 0;
   bit                nom_chk = 0;

   // Reference: a word becomes DATA_W bits LSB-first, each repeated REP times
   task automatic expect_word(input logic [DATA_W-1:0] w);
      for (int i = 0; i < DATA_W; i++)
         for (int r = 0; r < REP; r++)
            slot_q.push_back({w[i], (i == 0 && r == 0) ? 1'b1 : 1'b0});
      word_q.push_back(w);
   endtask

   always @(posedge CLK) begin
      #1;
      TX_READY = (rdy_mode != 0) ? 1'($urandom_range(0, 1)) : 1'b1;
   end

   // Monitor / loopback receiver state
   bit                stall_prev = 0;
   logic              prev_out, prev_sof;
   int                grp_pos = 0, grp_ones = 0, flip_idx = 0, bit_i = 0, slot_cnt = 0;
   logic [DATA_W-1:0] rx_word = '0;
   logic [NSLOT-1:0]  line_bits = '0;

   task automatic flush();
      slot_q.delete();
      word_q.delete();
      stall_prev = 0;
      grp_pos = 0; grp_ones = 0; bit_i = 0; slot_cnt = 0;
      rx_word = '0;
   endtask

   always @(negedge CLK) begin
      if (!RST) begin
         if (TX_VALID && stall_prev) begin
            chk("stall_out", TX_OUT, prev_out);
            chk("stall_sof", TX_SOF, prev_sof);
         end
         stall_prev = TX_VALID && !TX_READY;
         prev_out = TX_OUT;
         prev_sof = TX_SOF;
         if (TX_VALID && TX_READY) begin
            logic [1:0] e;
            if (slot_q.size() == 0) chk("unexpected_slot", 1, 0);
            else begin
               e = slot_q.pop_front();
               chk("slot_bit", TX_OUT, e[1]);
               chk("slot_sof", TX_SOF, e[0]);
            end
            if (slot_cnt < NSLOT) line_bits[slot_cnt] = TX_OUT;
            slot_cnt++;
            // Single injected error per group must be outvoted
            grp_ones += int'(TX_OUT ^ (grp_pos == flip_idx));
            grp_pos++;
            if (grp_pos == REP) begin
               if (bit_i < DATA_W) rx_word[bit_i] = (grp_ones > REP / 2);
               bit_i++;
               grp_pos = 0; grp_ones = 0;
               flip_idx = $urandom_range(0, REP - 1);
            end
         end
         if (DONE) begin
            if (word_q.size() == 0) chk("unexpected_done", 1, 0);
            else chk("loopback_word", rx_word, word_q.pop_front());
            chk("frame_slots", slot_cnt, NSLOT);
            if (nom_chk) chk("line_pattern", line_bits, 24'b111000111000000111000111);
            grp_pos = 0; grp_ones = 0; bit_i = 0; slot_cnt = 0; rx_word = '0;
         end
      end
   end

   task automatic send_word(input logic [DATA_W-1:0] w);
      int n = 0;
      while (!DIN_READY && n < 500) begin @(posedge CLK); #1; n++; end
      if (!DIN_READY) chk("din_ready_timeout", 0, 1);
      DIN = w;
      DIN_VALID = 1;
      expect_word(w);
      @(posedge CLK); #1;
      DIN_VALID = 0;
   endtask

   task automatic wait_done(output int cyc);
      cyc = 0;
      for (int i = 1; i <= 1000; i++) begin
         @(negedge CLK);
         if (DONE) begin cyc = i; break; end
      end
      if (cyc == 0) chk("done_timeout", 0, 1);
   endtask

   initial begin
      int cyc;
      logic [DATA_W-1:0] wb;
      // Reset values while held in reset
      #12;
      chk("rst_tx_out", TX_OUT, 0);
      chk("rst_tx_valid", TX_VALID, 0);
      chk("rst_tx_sof", TX_SOF, 0);
      chk("rst_done", DONE, 0);
      chk("rst_din_ready", DIN_READY, 0);
      @(posedge CLK); #1;
      DIN_VALID = 1; DIN = 8'h3C;
      RST = 0;
      @(negedge CLK);
      chk("rel_din_ready_low", DIN_READY, 0);
      DIN_VALID = 0;
      @(negedge CLK);
      chk("rel_din_ready_high", DIN_READY, 1);
      chk("rel_no_capture", TX_VALID, 0);

      // Assert reset while idle
      @(posedge CLK); #1;
      RST = 1; #1;
      chk("idle_rst_din_ready", DIN_READY, 0);
      chk("idle_rst_tx_valid", TX_VALID, 0);
      @(posedge CLK); #1;
      RST = 0;

      // Nominal frame
      nom_chk = 1;
      send_word(8'hA5);
      chk("first_slot_valid", TX_VALID, 1);
      chk("first_slot_sof", TX_SOF, 1);
      wait_done(cyc);
      chk("done_latency", cyc, NSLOT + 1);
      chk("done_din_ready", DIN_READY, 1);
      chk("done_tx_valid", TX_VALID, 0);

      // Backpressure on the same word
      rdy_mode = 1;
      send_word(8'hA5);
      wait_done(cyc);
      nom_chk = 0;
      rdy_mode = 0;

      // Busy-ignore: second word held valid during SEND
      wb = 8'h5E;
      send_word(8'hC3);
      DIN = wb; DIN_VALID = 1;
      expect_word(wb);
      @(negedge CLK);
      chk("busy_tx_valid", TX_VALID, 1);
      wait_done(cyc);
      @(posedge CLK); #1;
      DIN_VALID = 0;
      @(negedge CLK);
      chk("busy_next_valid", TX_VALID, 1);
      chk("busy_next_sof", TX_SOF, 1);
      wait_done(cyc);

      // Reset mid-frame at slot 10
      send_word(8'hFF);
      for (int i = 0; i < 100 && slot_cnt < 10; i++) begin @(posedge CLK); #1; end
      RST = 1; #1;
      chk("mid_rst_tx_valid", TX_VALID, 0);
      chk("mid_rst_tx_out", TX_OUT, 0);
      chk("mid_rst_din_ready", DIN_READY, 0);
      flush();
      @(posedge CLK); #1;
      RST = 0;
      send_word(8'h00);
      wait_done(cyc);
      chk("post_rst_done_latency", cyc, NSLOT + 1);

      // Random loopback with random backpressure
      rdy_mode = 1;
      for (int k = 0; k < 256; k++) begin
         send_word(DATA_W'($urandom));
         wait_done(cyc);
      end
      rdy_mode = 0;
      repeat (3) @(negedge CLK);
      chk("sb_slots_drained", slot_q.size(), 0);
      chk("sb_words_drained", word_q.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
